ps2_numpad_entry: RTL

PS2_NUMPAD_ENTRY -- requirements
Module: ps2_numpad_entry

---
 rtl/ps2_numpad_entry_if.sv | 29 ++
 rtl/ps2_numpad_entry.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_numpad_entry_if.sv
// ps2_numpad_entry_if -- bundles the keyboard lines, the scan-byte tap and the
// entry/value handshake of ps2_numpad_entry.
//   master : keyboard/consumer side (drives PS2_CLK, PS2_DATA, value_ack)
//   slave  : the entry block (drives rx_byte, rx_strobe, digits, count,
//            value, value_valid, frame_err)
interface ps2_numpad_entry_if #(
    parameter int NDIGITS = 4,
    parameter int OUT_W   = 32
) ();
    logic                 PS2_CLK;
    logic                 PS2_DATA;
    logic [7:0]           rx_byte;
    logic                 rx_strobe;
    logic [4*NDIGITS-1:0] digits;
    logic [3:0]           count;
    logic [OUT_W-1:0]     value;
    logic                 value_valid;
    logic                 value_ack;
    logic                 frame_err;

    modport master (
        output PS2_CLK, PS2_DATA, value_ack,
        input  rx_byte, rx_strobe, digits, count, value, value_valid, frame_err
    );
    modport slave (
        input  PS2_CLK, PS2_DATA, value_ack,
        output rx_byte, rx_strobe, digits, count, value, value_valid, frame_err
    );
endinterface

// File: rtl/ps2_numpad_entry.sv
// ps2_numpad_entry -- PS/2 keyboard receiver feeding a decimal numpad entry
// buffer. Digits are collected as BCD, Enter converts them to binary over
// count cycles and holds the result until value_ack.
// Ports:
//   clk, rst     : single clock, synchronous active-high reset
//   bus (slave)  : PS2_CLK/PS2_DATA in, rx_byte/rx_strobe scan tap,
//                  digits/count entry buffer, value/value_valid/value_ack
//                  result handshake, frame_err error pulse
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_numpad_entry #(
    parameter int NDIGITS = 4,
    parameter int OUT_W   = 32,
    parameter int TIMEOUT = 50000
) (
    input  logic                clk,
    input  logic                rst,
    ps2_numpad_entry_if.slave   bus
);
    localparam int DW = 4 * NDIGITS;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] F_IDLE = 2'd0, F_SHIFT = 2'd1, F_CHECK = 2'd2;
    localparam logic [1:0] E_ENTRY = 2'd0, E_CONVERT = 2'd1, E_HOLD = 2'd2;

    // ---------------- synchronisers / edge detect ----------------
    logic [1:0] clk_sync_q, dat_sync_q;
    logic       clk_prev_q;
    logic       fall, dat;

    assign fall = clk_prev_q & ~clk_sync_q[1];
    assign dat  = dat_sync_q[1];

    // ---------------- frame receiver ----------------
    logic [1:0]    fst_q, fst_d;
    logic [9:0]    sr_q, sr_d;          // {stop, parity, data[7:0]} once full
    logic [3:0]    bcnt_q, bcnt_d;
    logic [TW-1:0] to_q, to_d;
    logic          armed_q, armed_d;    // line seen quiet since reset
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_strobe_q, rx_strobe_d;
    logic          ferr_q, ferr_d;
    logic          par_bad;

`ifdef PS2_PARITY_CHECK_EN
    assign par_bad = ~(^sr_q[8:0]);
`else
    // parity bit is captured but deliberately ignored
    assign par_bad = sr_q[8] & 1'b0;
`endif

    always_comb begin
        fst_d       = fst_q;
        sr_d        = sr_q;
        bcnt_d      = bcnt_q;
        armed_d     = armed_q;
        rx_byte_d   = rx_byte_q;
        rx_strobe_d = 1'b0;
        ferr_d      = 1'b0;
        // saturating gap counter; a falling edge restarts it
        if (fall)                to_d = '0;
        else if (to_q != TO_MAX) to_d = to_q + 1'b1;
        else                     to_d = to_q;
        // after reset, only a quiet line may start a frame, so the tail of an
        // interrupted frame can never be mistaken for a start bit
        if (fst_q == F_IDLE && to_q == TO_MAX) armed_d = 1'b1;
        case (fst_q)
            F_IDLE: begin
                if (fall && !dat && armed_q) begin
                    fst_d  = F_SHIFT;
                    bcnt_d = '0;
                    sr_d   = '0;
                end
            end
            F_SHIFT: begin
                if (fall) begin
                    sr_d   = {dat, sr_q[9:1]};
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == 4'd9) fst_d = F_CHECK;
                end else if (to_q == TO_MAX) begin
                    fst_d  = F_IDLE;
                    sr_d   = '0;
                    ferr_d = 1'b1;
                end
            end
            default: begin
                fst_d = F_IDLE;
                if (!sr_q[9] || par_bad) begin
                    ferr_d = 1'b1;
                end else begin
                    rx_byte_d   = sr_q[7:0];
                    rx_strobe_d = 1'b1;
                end
            end
        endcase
    end

    // ---------------- scan-code decode ----------------
    logic       brk_q, brk_d, ext_q, ext_d;
    logic [3:0] kdig;
    logic       is_dig, is_ent, is_bs, is_esc, key_go;

    always_comb begin
        kdig = 4'd0; is_dig = 1'b1; is_ent = 1'b0; is_bs = 1'b0; is_esc = 1'b0;
        case (rx_byte_q)
            8'h70: kdig = 4'd0;
            8'h69: kdig = 4'd1;
            8'h72: kdig = 4'd2;
            8'h7A: kdig = 4'd3;
            8'h6B: kdig = 4'd4;
            8'h73: kdig = 4'd5;
            8'h74: kdig = 4'd6;
            8'h6C: kdig = 4'd7;
            8'h75: kdig = 4'd8;
            8'h7D: kdig = 4'd9;
            8'h5A: begin is_dig = 1'b0; is_ent = 1'b1; end
            8'h66: begin is_dig = 1'b0; is_bs  = 1'b1; end
            8'h76: begin is_dig = 1'b0; is_esc = 1'b1; end
            default: is_dig = 1'b0;
        endcase
    end

    // prefixes never reach the entry FSM; the byte after F0 is a key release
    assign key_go = rx_strobe_q & ~brk_q & (rx_byte_q != 8'hF0) & (rx_byte_q != 8'hE0);

    always_comb begin
        brk_d = brk_q;
        ext_d = ext_q;
        if (rx_strobe_q) begin
            if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (rx_byte_q == 8'hF0) brk_d = 1'b1;
            else if (rx_byte_q == 8'hE0)      ext_d = 1'b1;
            else                              ext_d = 1'b0;
        end
    end

    // ---------------- entry / convert ----------------
    logic [1:0]       est_q, est_d;
    logic [DW-1:0]    digits_q, digits_d, dsh;
    logic [3:0]       cnt_q, cnt_d, cidx_q, cidx_d;
    logic [OUT_W-1:0] value_q, value_d;
    logic             vv_q, vv_d;

    // nibble cidx-1 walks from the most significant entered digit down
    assign dsh = digits_q >> (4 * (cidx_q - 4'd1));

    always_comb begin
        est_d    = est_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        cidx_d   = cidx_q;
        value_d  = value_q;
        vv_d     = vv_q;
        case (est_q)
            E_ENTRY: begin
                if (key_go) begin
                    if (is_dig && cnt_q < 4'(NDIGITS)) begin
                        digits_d = (digits_q << 4) | DW'(kdig);
                        cnt_d    = cnt_q + 1'b1;
                    end else if (is_bs && cnt_q != 4'd0) begin
                        digits_d = digits_q >> 4;
                        cnt_d    = cnt_q - 1'b1;
                    end else if (is_esc) begin
                        digits_d = '0;
                        cnt_d    = '0;
                    end else if (is_ent && cnt_q != 4'd0) begin
                        est_d   = E_CONVERT;
                        cidx_d  = cnt_q;
                        value_d = '0;
                    end
                end
            end
            E_CONVERT: begin
                value_d = value_q * OUT_W'(10) + OUT_W'(dsh[3:0]);
                cidx_d  = cidx_q - 1'b1;
                if (cidx_q == 4'd1) begin
                    est_d = E_HOLD;
                    vv_d  = 1'b1;
                end
            end
            default: begin
                if (bus.value_ack) begin
                    est_d    = E_ENTRY;
                    vv_d     = 1'b0;
                    digits_d = '0;
                    cnt_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            clk_prev_q  <= 1'b1;
            fst_q       <= F_IDLE;
            sr_q        <= '0;
            bcnt_q      <= '0;
            to_q        <= '0;
            armed_q     <= 1'b0;
            rx_byte_q   <= '0;
            rx_strobe_q <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            est_q       <= E_ENTRY;
            digits_q    <= '0;
            cnt_q       <= '0;
            cidx_q      <= '0;
            value_q     <= '0;
            vv_q        <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], bus.PS2_CLK};
            dat_sync_q  <= {dat_sync_q[0], bus.PS2_DATA};
            clk_prev_q  <= clk_sync_q[1];
            fst_q       <= fst_d;
            sr_q        <= sr_d;
            bcnt_q      <= bcnt_d;
            to_q        <= to_d;
            armed_q     <= armed_d;
            rx_byte_q   <= rx_byte_d;
            rx_strobe_q <= rx_strobe_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            est_q       <= est_d;
            digits_q    <= digits_d;
            cnt_q       <= cnt_d;
            cidx_q      <= cidx_d;
            value_q     <= value_d;
            vv_q        <= vv_d;
        end
    end

    assign bus.rx_byte     = rx_byte_q;
    assign bus.rx_strobe   = rx_strobe_q;
    assign bus.digits      = digits_q;
    assign bus.count       = cnt_q;
    assign bus.value       = value_q;
    assign bus.value_valid = vv_q;
    assign bus.frame_err   = ferr_q;
endmodule
